toggle_counter: RTL and testbench
=================================

# toggle_counter

Synchronous WIDTH-bit up/down counter built as a bank of T flip-flop stages driven by a generated toggle vector. It is the control stage that sits directly upstream of a T flip-flop bank: it computes which bits must toggle each cycle, applies them, and exposes both the resulting count and the applied toggle vector to downstream logic. It also provides a terminal-count pulse for cascading counters or time bases.

## Interface
- WIDTH, 4: counter width in bits, minimum 1.
- MAX, 2**WIDTH-1: highest count value, where the counter wraps. Legal range is 1 to 2**WIDTH-1.
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- en  in  1  count enable.
- up  in  1  direction: 1 counts up, 0 counts down.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  registered counter state.
- toggle  out  WIDTH  registered toggle vector applied at the last edge (count_new XOR count_old).
- tc  out  1  registered terminal-count pulse.

## Operation
- Priority at each rising edge is rst, then load, then en, then hold.
- **rst:** count=0, toggle=0, tc=0.
- **load:** count = min(load_val, MAX).
  - toggle = old count XOR new count.
  - tc=0.
  - en and up are ignored.
- **en, up=1:**
  - count < MAX: toggle bit i = AND of count[i-1:0]. Bit 0 always toggles.
  - count == MAX: wraps to 0, toggle = MAX, tc=1.
- **en, up=0:**
  - count > 0: toggle bit i = AND of ~count[i-1:0].
  - count == 0: wraps to MAX, toggle = MAX, tc=1.
- **Hold** (no rst, load or en): count unchanged, toggle=0, tc=0.
- count is always the old count XOR toggle; no other write path exists.
- tc is high for exactly one cycle per wrap. With en held continuously it pulses once every MAX+1 cycles.
- Changing direction (up) while counting takes effect on the next enabled edge, with no extra cycle.
- Invariant: count never exceeds MAX.

## Timing
- Latency from sampled inputs to the count, toggle and tc outputs is 1 cycle. All outputs come from flops; there is no combinational path from inputs to outputs.
- rst asserted mid-count clears every output at the same edge. The first count after rst deasserts occurs on the next edge with en=1.
- load and en asserted together: load wins, and no count step happens that cycle.
- WIDTH=1, MAX=1: the block behaves as a single toggle flip-flop. tc pulses on every 1→0 step up and every 0→1 step down.

## Configuration
- TOGGLE_COUNTER_SAT_EN defined: saturating mode.
  - up at MAX holds count at MAX with toggle=0.
  - down at 0 holds count at 0 with toggle=0.
  - tc=1 on every enabled cycle in which the counter is held at a limit.
- TOGGLE_COUNTER_SAT_EN undefined: wrap mode, exactly as described under Operation.

## Structure
- Package toggle_counter_pkg holds:
  - DIR_UP=1'b1 and DIR_DOWN=1'b0.
  - DEFAULT_WIDTH=4.
  - a function that returns the toggle vector for a given count, direction and MAX.
- Sub-module tff_cell is one bit of the bank. It has:
  - clk, rst (sync, active-high), t, ld, d, and output q.
  - Behaviour: q<=0 on rst; q<=d on ld; q<=q^t otherwise.
  - toggle_counter instantiates WIDTH copies and drives their t inputs from the generated vector.

## Test plan
- **Reset mid-count:** WIDTH=4, en=1, up=1, reset released; after 5 edges count=5. Then pulse rst at count=9 → same edge gives count=0, toggle=0, tc=0.
- **Up wrap:** MAX=15, up=1, en held for 16 edges. Expected count sequence 1..15 then 0. On the 15→0 edge toggle=4'b1111 and tc=1 for one cycle only.
- **Down wrap with MAX=9:** load 0, then en=1, up=0 → count=9, toggle=4'b1001, tc=1. The next edge gives count=8, toggle=4'b0001, tc=0.
- **Load priority and clamp:** count=3, load=1, en=1, load_val=12, MAX=9 → count=9, toggle=4'b1010, tc=0.
- **Hold and direction change:** count=6, en=0 for 3 edges → count stays 6, toggle=0. Then en=1 with up alternating 1,0 → count goes 7, then 6.
- **TOGGLE_COUNTER_SAT_EN defined:** count=15 with up=1 for 3 enabled edges → count stays 15, toggle=0, tc=1 on each of those edges.

Source files
------------

// File: rtl/toggle_counter_pkg.sv
// toggle_counter_pkg: shared constants and toggle-vector helper.
// Used by toggle_counter and its T flip-flop bank.
package toggle_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEFAULT_WIDTH = 4;

  // Widest counter the helper function supports
  localparam int TC_VEC_W = 32;

  // Bits that must flip to take one step from cnt in direction dir.
  // At a limit: wrap (toggle = max_v) or hold (toggle = 0) when sat.
  function automatic logic [TC_VEC_W-1:0] next_toggle(
    input logic [TC_VEC_W-1:0] cnt,
    input logic                dir,
    input logic [TC_VEC_W-1:0] max_v,
    input logic                sat
  );
    logic [TC_VEC_W-1:0] t;
    logic                carry;
    t     = '0;
    carry = 1'b1;
    if ((dir == DIR_UP) && (cnt == max_v)) begin
      t = sat ? '0 : max_v;
    end else if ((dir == DIR_DOWN) && (cnt == '0)) begin
      t = sat ? '0 : max_v;
    end else begin
      for (int i = 0; i < TC_VEC_W; i++) begin
        t[i]  = carry;
        carry = carry & ((dir == DIR_UP) ? cnt[i] : ~cnt[i]);
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/toggle_counter_tff_cell.sv
// tff_cell: one bit of the T flip-flop bank.
// Sync active-high reset, parallel load, else toggle on t.
module tff_cell
  import toggle_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic ld,
  input  logic d,
  output logic q
);

  logic q_q;
  logic q_d;

  // Next bit value: load has priority over toggling
  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else begin
      q_d = q_q ^ t;
    end
  end

  // Bit register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/toggle_counter.sv
// toggle_counter: up/down counter built on a T flip-flop bank.
// Define TOGGLE_COUNTER_SAT_EN for saturating instead of wrapping.
module toggle_counter
  import toggle_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int MAX   = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] toggle,
  output logic             tc
);

`ifdef TOGGLE_COUNTER_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_w;
  logic [WIDTH-1:0] step_vec;
  logic [WIDTH-1:0] load_c;
  logic             at_lim;

  logic [WIDTH-1:0] cell_t;
  logic             cell_ld;

  logic [WIDTH-1:0] toggle_q;
  logic [WIDTH-1:0] toggle_d;
  logic             tc_q;
  logic             tc_d;

  // Step vector, limit detect and clamped load value
  always_comb begin
    step_vec = WIDTH'(next_toggle(TC_VEC_W'(count_w), up,
                                  TC_VEC_W'(MAX_V), SAT));
    at_lim   = (up == DIR_UP) ? (count_w == MAX_V)
                              : (count_w == '0);
    load_c   = (load_val > MAX_V) ? MAX_V : load_val;
  end

  // Control: priority rst > load > en > hold
  always_comb begin
    cell_t   = '0;
    cell_ld  = 1'b0;
    toggle_d = '0;
    tc_d     = 1'b0;
    if (rst) begin
      toggle_d = '0;
    end else if (load) begin
      cell_ld  = 1'b1;
      toggle_d = count_w ^ load_c;
    end else if (en) begin
      cell_t   = step_vec;
      toggle_d = step_vec;
      tc_d     = at_lim;
    end
  end

  // Status registers that mirror the applied step
  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
      tc_q     <= tc_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (cell_t[i]),
      .ld  (cell_ld),
      .d   (load_c[i]),
      .q   (count_w[i])
    );
  end

  assign count  = count_w;
  assign toggle = toggle_q;
  assign tc     = tc_q;

endmodule

// File: tb/tb_toggle_counter.sv
// tb_toggle_counter: directed checks on three toggle_counter builds
// (W4/MAX15, W4/MAX9, W1/MAX1).
module tb_toggle_counter;

`ifdef TOGGLE_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] a_count, a_toggle;
  logic       a_tc;
  logic [3:0] b_count, b_toggle;
  logic       b_tc;
  logic [0:0] c_count, c_toggle;
  logic       c_tc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  toggle_counter #(.WIDTH(4), .MAX(15)) u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(a_count),
    .toggle(a_toggle), .tc(a_tc));

  toggle_counter #(.WIDTH(4), .MAX(9)) u_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(b_count),
    .toggle(b_toggle), .tc(b_tc));

  toggle_counter #(.WIDTH(1), .MAX(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val[0:0]), .count(c_count),
    .toggle(c_toggle), .tc(c_tc));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; up = 1'b1;
    step();
    checks++;
    if (a_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_count got %h exp 0", a_count);
    end
    checks++;
    if (a_toggle !== 4'd0 || a_tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_tog_tc got %h/%b exp 0/0",
               a_toggle, a_tc);
    end
    rst = 1'b0; en = 1'b1;
    repeat (5) step();
    checks++;
    if (a_count !== 4'd5 || a_toggle !== 4'b0001) begin
      errors++;
      $display("FAIL count5 got %h/%b exp 5/0001",
               a_count, a_toggle);
    end
    repeat (4) step();
    checks++;
    if (a_count !== 4'd9) begin
      errors++;
      $display("FAIL count9 got %h exp 9", a_count);
    end
    rst = 1'b1;
    step();
    checks++;
    if (a_count !== 4'd0 || a_toggle !== 4'd0 || a_tc !== 1'b0) begin
      errors++;
      $display("FAIL midrst got %h/%h/%b exp 0/0/0",
               a_count, a_toggle, a_tc);
    end
    rst = 1'b0; en = 1'b0;
  endtask

  task automatic test_up_wrap();
    logic [3:0] exp_c, prev, exp_t;
    logic       exp_tc;
    rst = 1'b1; en = 1'b0; load = 1'b0;
    step();
    rst = 1'b0; en = 1'b1; up = 1'b1;
    exp_c = 4'd0;
    for (int i = 1; i <= 17; i++) begin
      prev = exp_c;
      if (prev == 4'hF) begin
        exp_c  = SAT ? 4'hF : 4'h0;
        exp_tc = 1'b1;
      end else begin
        exp_c  = prev + 4'd1;
        exp_tc = 1'b0;
      end
      exp_t = prev ^ exp_c;
      step();
      checks++;
      if (a_count !== exp_c || a_toggle !== exp_t
          || a_tc !== exp_tc) begin
        errors++;
        $display("FAIL up_wrap step %0d got %h/%h/%b exp %h/%h/%b",
                 i, a_count, a_toggle, a_tc, exp_c, exp_t, exp_tc);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_down_wrap();
    load = 1'b1; load_val = 4'd0; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0;
    step();
    checks++;
    if (b_count !== (SAT ? 4'd0 : 4'd9)
        || b_toggle !== (SAT ? 4'b0000 : 4'b1001)
        || b_tc !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap got %h/%b/%b", b_count, b_toggle, b_tc);
    end
    step();
    checks++;
    if (b_count !== (SAT ? 4'd0 : 4'd8)
        || b_toggle !== (SAT ? 4'b0000 : 4'b0001)
        || b_tc !== SAT) begin
      errors++;
      $display("FAIL down_next got %h/%b/%b", b_count, b_toggle, b_tc);
    end
    en = 1'b0; up = 1'b1;
  endtask

  task automatic test_load_clamp();
    load = 1'b1; load_val = 4'd3; en = 1'b0;
    step();
    checks++;
    if (a_count !== 4'd3 || b_count !== 4'd3) begin
      errors++;
      $display("FAIL load3 got %h/%h exp 3/3", a_count, b_count);
    end
    load = 1'b1; en = 1'b1; up = 1'b1; load_val = 4'd12;
    step();
    checks++;
    if (b_count !== 4'd9 || b_toggle !== 4'b1010 || b_tc !== 1'b0) begin
      errors++;
      $display("FAIL clamp got %h/%b/%b exp 9/1010/0",
               b_count, b_toggle, b_tc);
    end
    checks++;
    if (a_count !== 4'd12 || a_toggle !== 4'b1111 || a_tc !== 1'b0) begin
      errors++;
      $display("FAIL load12 got %h/%b/%b exp c/1111/0",
               a_count, a_toggle, a_tc);
    end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_hold_dir();
    load = 1'b1; load_val = 4'd6;
    step();
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (a_count !== 4'd6 || a_toggle !== 4'd0 || a_tc !== 1'b0) begin
        errors++;
        $display("FAIL hold %0d got %h/%h/%b exp 6/0/0",
                 i, a_count, a_toggle, a_tc);
      end
    end
    en = 1'b1; up = 1'b1;
    step();
    checks++;
    if (a_count !== 4'd7 || a_toggle !== 4'b0001) begin
      errors++;
      $display("FAIL dir_up got %h/%b exp 7/0001", a_count, a_toggle);
    end
    up = 1'b0;
    step();
    checks++;
    if (a_count !== 4'd6 || a_toggle !== 4'b0001) begin
      errors++;
      $display("FAIL dir_dn got %h/%b exp 6/0001", a_count, a_toggle);
    end
    en = 1'b0; up = 1'b1;
  endtask

  task automatic test_limits();
    logic [3:0] exp_c [3];
    exp_c = '{4'd0, 4'd1, 4'd2};
    load = 1'b1; load_val = 4'd15;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (a_count !== (SAT ? 4'd15 : exp_c[i])
          || a_tc !== (SAT ? 1'b1 : (i == 0))) begin
        errors++;
        $display("FAIL up_limit %0d got %h/%h/%b", i,
                 a_count, a_toggle, a_tc);
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0; up = 1'b0;
    step();
    checks++;
    if (a_count !== (SAT ? 4'd0 : 4'd15)
        || a_toggle !== (SAT ? 4'd0 : 4'hF) || a_tc !== 1'b1) begin
      errors++;
      $display("FAIL dn_limit got %h/%h/%b", a_count, a_toggle, a_tc);
    end
    en = 1'b0; up = 1'b1;
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      if (a_tc === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== (SAT ? 17 : 2)) begin
      errors++;
      $display("FAIL tc_period got %0d pulses exp %0d",
               pulses, SAT ? 17 : 2);
    end
    en = 1'b0;
  endtask

  task automatic test_width1();
    logic [0:0] wc [6];
    logic [0:0] sc [6];
    logic [0:0] wt [6];
    logic [0:0] st [6];
    logic       wtc [6];
    logic       stc [6];
    wc  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    wt  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    wtc = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    sc  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    st  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    stc = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      up = (i < 4) ? 1'b1 : 1'b0;
      step();
      checks++;
      if (c_count !== (SAT ? sc[i] : wc[i])
          || c_toggle !== (SAT ? st[i] : wt[i])
          || c_tc !== (SAT ? stc[i] : wtc[i])) begin
        errors++;
        $display("FAIL w1 step %0d got %b/%b/%b", i,
                 c_count, c_toggle, c_tc);
      end
    end
    en = 1'b0; up = 1'b1;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_clamp();
    test_hold_dir();
    test_limits();
    test_back_to_back();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
